// File: rtl/camera_controller_if.sv
// Frame-strobe, button/target inputs and camera position outputs of camera_controller.
// The slave modport is the controller's side; the master modport is the side that drives frames.
interface camera_controller_if #(
  parameter int unsigned WORLD_BITS = 18
);
  logic                         new_frame_in;
  logic [3:0]                   btn_in;
  logic                         mode_in;
  logic signed [WORLD_BITS-1:0] target_x_in;
  logic signed [WORLD_BITS-1:0] target_y_in;
  logic signed [WORLD_BITS-1:0] camera_x_out;
  logic signed [WORLD_BITS-1:0] camera_y_out;
  logic                         update_out;
  logic                         moving_out;

  modport master (
    output new_frame_in, btn_in, mode_in, target_x_in, target_y_in,
    input  camera_x_out, camera_y_out, update_out, moving_out
  );

  modport slave (
    input  new_frame_in, btn_in, mode_in, target_x_in, target_y_in,
    output camera_x_out, camera_y_out, update_out, moving_out
  );
endinterface

// File: rtl/camera_controller.sv
// Per-frame camera update: manual buttons with step acceleration, or dead-zone follow of a target.
// Optional macro CAMERA_CLAMP_EN saturates the new position to [MIN, MAX]; otherwise it wraps.
module camera_controller #(
  parameter int unsigned WORLD_BITS   = 18,
  parameter int          INIT_X       = 640,
  parameter int          INIT_Y       = 360,
  parameter int unsigned STEP_MIN     = 1,
  parameter int unsigned STEP_MAX     = 16,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned DEADZONE_X   = 200,
  parameter int unsigned DEADZONE_Y   = 100,
  parameter int unsigned FOLLOW_SHIFT = 3,
  parameter int          MIN_X        = 0,
  parameter int          MAX_X        = 65535,
  parameter int          MIN_Y        = 0,
  parameter int          MAX_Y        = 65535
) (
  input logic                clk_in,
  input logic                rst_in,
  camera_controller_if.slave bus
);
  localparam int unsigned SW     = WORLD_BITS + 2;
  localparam int unsigned STEP_W = $clog2(STEP_MAX) + 1;
  localparam int unsigned HOLD_W = $clog2(ACCEL_FRAMES) + 1;

  typedef logic signed [WORLD_BITS-1:0] coord_t;
  typedef logic signed [SW-1:0]         wide_t;
  typedef enum logic [1:0] {IDLE, CALC, CLAMP, COMMIT} state_t;

  if (STEP_MIN > STEP_MAX || MIN_X > MAX_X || MIN_Y > MAX_Y) begin : g_bad_cfg
    $error("camera_controller: inconsistent step or clamp parameters");
  end

  state_t              state_q, state_d;
  logic                sample_c, calc_c, clamp_c, commit_c;
  logic [3:0]          btn_q;
  logic                mode_q, mode_chg_q;
  coord_t              tx_q, ty_q;
  logic [STEP_W-1:0]   step_q, step_d, step_eff_c;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_eff_c;
  wide_t               dx_c, dy_c, dx_q, dy_q;
  wide_t               sx_c, sy_c;
  coord_t              nx_c, ny_c, nx_q, ny_q;
  logic                mv_c, mv_q, commit_q;
  coord_t              cam_x_q, cam_y_q;
  logic                update_q, moving_q;

  function automatic wide_t man_delta(input logic pos, input logic neg, input wide_t step);
    if (pos && !neg) return step;
    if (neg && !pos) return -step;
    return '0;
  endfunction

  // Distance beyond the dead zone, scaled down, never stalling at zero once outside it.
  function automatic wide_t follow_delta(input wide_t tgt, input wide_t cam, input wide_t dz);
    wide_t d;
    wide_t r;
    d = tgt - cam;
    r = '0;
    if (d > dz) begin
      r = (d - dz) >>> FOLLOW_SHIFT;
      if (r == '0) r = wide_t'(1);
    end else if (d < -dz) begin
      r = (d + dz) >>> FOLLOW_SHIFT;
      if (r == '0) r = wide_t'(-1);
    end
    return r;
  endfunction

`ifdef CAMERA_CLAMP_EN
  function automatic coord_t sat(input wide_t v, input int lo, input int hi);
    if (v < wide_t'(lo)) return coord_t'(lo);
    if (v > wide_t'(hi)) return coord_t'(hi);
    return coord_t'(v);
  endfunction
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.new_frame_in) state_d = CALC;
      CALC:    state_d = CLAMP;
      CLAMP:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_c = 1'b0;
    calc_c   = 1'b0;
    clamp_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE:    sample_c = bus.new_frame_in;
      CALC:    calc_c   = 1'b1;
      CLAMP:   clamp_c  = 1'b1;
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // A mode switch restarts acceleration on the very frame that switched.
  always_comb begin
    step_d     = step_q;
    hold_d     = hold_q;
    step_eff_c = mode_chg_q ? STEP_W'(STEP_MIN) : step_q;
    hold_eff_c = mode_chg_q ? '0 : hold_q;
    if (mode_q) begin
      dx_c = follow_delta(wide_t'(tx_q), wide_t'(cam_x_q), wide_t'(DEADZONE_X));
      dy_c = follow_delta(wide_t'(ty_q), wide_t'(cam_y_q), wide_t'(DEADZONE_Y));
    end else begin
      dx_c = man_delta(btn_q[2], btn_q[3], wide_t'(step_eff_c));
      dy_c = man_delta(btn_q[0], btn_q[1], wide_t'(step_eff_c));
    end
    if (calc_c) begin
      if (mode_q || !(|btn_q)) begin
        step_d = STEP_W'(STEP_MIN);
        hold_d = '0;
      end else if (hold_eff_c == HOLD_W'(ACCEL_FRAMES - 1)) begin
        hold_d = '0;
        step_d = (step_eff_c >= STEP_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : (step_eff_c << 1);
      end else begin
        hold_d = hold_eff_c + HOLD_W'(1);
        step_d = step_eff_c;
      end
    end
  end

  always_comb begin
    sx_c = wide_t'(cam_x_q) + dx_q;
    sy_c = wide_t'(cam_y_q) + dy_q;
`ifdef CAMERA_CLAMP_EN
    nx_c = sat(sx_c, MIN_X, MAX_X);
    ny_c = sat(sy_c, MIN_Y, MAX_Y);
`else
    nx_c = coord_t'(sx_c);
    ny_c = coord_t'(sy_c);
`endif
    mv_c = (nx_c != cam_x_q) || (ny_c != cam_y_q);
  end

  // Outputs land one cycle after COMMIT through the commit_q stage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_q      <= '0;
      mode_q     <= 1'b0;
      mode_chg_q <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      step_q     <= STEP_W'(STEP_MIN);
      hold_q     <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      mv_q       <= 1'b0;
      commit_q   <= 1'b0;
      update_q   <= 1'b0;
      moving_q   <= 1'b0;
      cam_x_q    <= coord_t'(INIT_X);
      cam_y_q    <= coord_t'(INIT_Y);
    end else begin
      if (sample_c) begin
        btn_q      <= bus.btn_in;
        mode_chg_q <= bus.mode_in != mode_q;
        mode_q     <= bus.mode_in;
        tx_q       <= bus.target_x_in;
        ty_q       <= bus.target_y_in;
      end
      if (calc_c) begin
        dx_q <= dx_c;
        dy_q <= dy_c;
      end
      step_q <= step_d;
      hold_q <= hold_d;
      if (clamp_c) begin
        nx_q <= nx_c;
        ny_q <= ny_c;
        mv_q <= mv_c;
      end
      commit_q <= commit_c;
      update_q <= commit_q;
      if (commit_q) begin
        cam_x_q  <= nx_q;
        cam_y_q  <= ny_q;
        moving_q <= mv_q;
      end
    end
  end

  assign bus.camera_x_out = cam_x_q;
  assign bus.camera_y_out = cam_y_q;
  assign bus.update_out   = update_q;
  assign bus.moving_out   = moving_q;
endmodule
